// File: rtl/ast_frame_arbiter_pkg.sv
// Shared packet-type constants and arbiter FSM encoding.
// The bt656 video blocks reuse the packet-type constants.
package ast_frame_arbiter_pkg;

    localparam logic [3:0] PKT_CTRL  = 4'hF;
    localparam logic [3:0] PKT_VIDEO = 4'h0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_DROP = 2'd2
    } fsm_state_e;

    function automatic logic is_ctrl(input logic [3:0] pkt_type);
        return pkt_type == PKT_CTRL;
    endfunction

endpackage

// File: rtl/ast_skid_buffer.sv
// Two-entry Avalon-ST skid buffer with registered outputs.
// Handshake: a beat moves on any edge where valid and ready are both high; in_ready is "not full".
module ast_skid_buffer #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             push;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        push         = in_valid && !skid_valid_q;

        // The output register refills whenever it is empty or being drained;
        // the skid entry always has priority so beat order is preserved.
        if (!out_valid_q || out_ready) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = push;
                if (push) begin
                    out_data_d = in_data;
                end
            end
        end else if (push) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

    assign in_ready  = !skid_valid_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: rtl/ast_frame_arbiter.sv
// Two-input Avalon-ST frame arbiter: grants whole control+video frame sequences per input,
// drops packets that do not start with a control header, and never interleaves inputs.
module ast_frame_arbiter
    import ast_frame_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH       = 8,
    parameter int FRAMES_PER_GRANT = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] din0_data,
    input  logic                  din0_valid,
    input  logic                  din0_startofpacket,
    input  logic                  din0_endofpacket,
    output logic                  din0_ready,
    input  logic [DATA_WIDTH-1:0] din1_data,
    input  logic                  din1_valid,
    input  logic                  din1_startofpacket,
    input  logic                  din1_endofpacket,
    output logic                  din1_ready,
    output logic [DATA_WIDTH-1:0] dout_data,
    output logic                  dout_valid,
    output logic                  dout_startofpacket,
    output logic                  dout_endofpacket,
    input  logic                  dout_ready,
    output logic                  grant,
    output logic                  busy,
    output logic [15:0]           frame_count,
    output logic [15:0]           drop_count,
    output fsm_state_e            dbg_state
);

    localparam int         BW  = DATA_WIDTH + 2;
    localparam logic [7:0] FPG = 8'(FRAMES_PER_GRANT);

    fsm_state_e  state_q, state_d;
    logic        grant_q, grant_d;
    logic        last_grant_q, last_grant_d;
    logic [7:0]  fig_q, fig_d;
    logic [15:0] frame_count_q, frame_count_d;
    logic [15:0] drop_count_q, drop_count_d;
    logic [3:0]  type_q, type_d;

    logic [DATA_WIDTH-1:0] sel_data;
    logic                  sel_valid, sel_sop, sel_eop, sel_ready, accept;
    logic                  cand0, cand1, win;
    logic [3:0]            head_type, cur_type;
    logic                  buf_in_valid, buf_in_ready;
    logic [BW-1:0]         buf_in_data, buf_out_data;

    always_comb begin
        sel_data  = grant_q ? din1_data          : din0_data;
        sel_valid = grant_q ? din1_valid         : din0_valid;
        sel_sop   = grant_q ? din1_startofpacket : din0_startofpacket;
        sel_eop   = grant_q ? din1_endofpacket   : din0_endofpacket;
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        fig_d         = fig_q;
        frame_count_d = frame_count_q;
        drop_count_d  = drop_count_q;
        type_d        = type_q;
        sel_ready     = 1'b0;
        buf_in_valid  = 1'b0;

        cand0     = din0_valid && din0_startofpacket;
        cand1     = din1_valid && din1_startofpacket;
        win       = (cand0 && cand1) ? !last_grant_q : cand1;
        head_type = win ? din1_data[3:0] : din0_data[3:0];
        // A one-beat packet carries its type on the same beat as its EOP.
        cur_type  = sel_sop ? sel_data[3:0] : type_q;
        accept    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cand0 || cand1) begin
                    grant_d = win;
                    if (is_ctrl(head_type)) begin
                        fig_d   = 8'd0;
                        state_d = ST_FWD;
                    end else begin
                        state_d = ST_DROP;
                    end
                end
            end
            ST_FWD: begin
                sel_ready    = buf_in_ready;
                buf_in_valid = sel_valid;
                accept       = sel_valid && sel_ready;
                if (accept && sel_sop) begin
                    type_d = sel_data[3:0];
                end
                if (accept && sel_eop && cur_type == PKT_VIDEO) begin
                    frame_count_d = frame_count_q + 16'd1;
                    fig_d         = fig_q + 8'd1;
                    if (fig_q + 8'd1 == FPG) begin
                        last_grant_d = grant_q;
                        state_d      = ST_IDLE;
                    end
                end
            end
            ST_DROP: begin
                sel_ready = 1'b1;
                accept    = sel_valid;
                if (accept && sel_eop) begin
                    drop_count_d = drop_count_q + 16'd1;
                    last_grant_d = grant_q;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            grant_q       <= 1'b0;
            last_grant_q  <= 1'b1;
            fig_q         <= 8'd0;
            frame_count_q <= 16'd0;
            drop_count_q  <= 16'd0;
            type_q        <= 4'd0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_grant_q  <= last_grant_d;
            fig_q         <= fig_d;
            frame_count_q <= frame_count_d;
            drop_count_q  <= drop_count_d;
            type_q        <= type_d;
        end
    end

    assign buf_in_data = {sel_sop, sel_eop, sel_data};

    ast_skid_buffer #(.WIDTH(BW)) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (buf_in_valid),
        .in_ready (buf_in_ready),
        .in_data  (buf_in_data),
        .out_valid(dout_valid),
        .out_ready(dout_ready),
        .out_data (buf_out_data)
    );

    assign {dout_startofpacket, dout_endofpacket, dout_data} = buf_out_data;

    assign din0_ready  = sel_ready && !grant_q;
    assign din1_ready  = sel_ready && grant_q;
    assign grant       = grant_q;
    assign busy        = state_q != ST_IDLE;
    assign frame_count = frame_count_q;
    assign drop_count  = drop_count_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_ast_frame_arbiter.sv
// Directed bench for ast_frame_arbiter: dut0 uses one frame per grant, dut1 uses two.
// Packets go into per-input source queues; forwarded beats are expected in arbitration order.
module tb_ast_frame_arbiter;
    import ast_frame_arbiter_pkg::*;

    typedef logic [9:0] beat_t;

    logic clk;
    logic rst_n;

    logic [1:0][7:0]  a_data, b_data, o_data;
    logic [1:0]       a_valid, a_sop, a_eop, a_ready;
    logic [1:0]       b_valid, b_sop, b_eop, b_ready;
    logic [1:0]       o_valid, o_sop, o_eop, o_rdy;
    logic [1:0]       grant, busy;
    logic [1:0][15:0] fcnt, dcnt;
    fsm_state_e       st0, st1;

    beat_t sq0a[$], sq0b[$], sq1a[$], sq1b[$];
    logic [9:0] exp_q0[$], exp_q1[$];
    bit acc0a, acc0b, acc1a, acc1b;
    bit rnd_rdy;
    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ast_frame_arbiter #(.DATA_WIDTH(8), .FRAMES_PER_GRANT(1)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .din0_data(a_data[0]), .din0_valid(a_valid[0]), .din0_startofpacket(a_sop[0]),
        .din0_endofpacket(a_eop[0]), .din0_ready(a_ready[0]),
        .din1_data(b_data[0]), .din1_valid(b_valid[0]), .din1_startofpacket(b_sop[0]),
        .din1_endofpacket(b_eop[0]), .din1_ready(b_ready[0]),
        .dout_data(o_data[0]), .dout_valid(o_valid[0]), .dout_startofpacket(o_sop[0]),
        .dout_endofpacket(o_eop[0]), .dout_ready(o_rdy[0]),
        .grant(grant[0]), .busy(busy[0]), .frame_count(fcnt[0]), .drop_count(dcnt[0]),
        .dbg_state(st0)
    );

    ast_frame_arbiter #(.DATA_WIDTH(8), .FRAMES_PER_GRANT(2)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .din0_data(a_data[1]), .din0_valid(a_valid[1]), .din0_startofpacket(a_sop[1]),
        .din0_endofpacket(a_eop[1]), .din0_ready(a_ready[1]),
        .din1_data(b_data[1]), .din1_valid(b_valid[1]), .din1_startofpacket(b_sop[1]),
        .din1_endofpacket(b_eop[1]), .din1_ready(b_ready[1]),
        .dout_data(o_data[1]), .dout_valid(o_valid[1]), .dout_startofpacket(o_sop[1]),
        .dout_endofpacket(o_eop[1]), .dout_ready(o_rdy[1]),
        .grant(grant[1]), .busy(busy[1]), .frame_count(fcnt[1]), .drop_count(dcnt[1]),
        .dbg_state(st1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Beats are {sop, eop, data}; fwd selects whether the packet must appear on dout.
    task automatic push_pkt(input int d, input int p, input logic [7:0] head, input int len,
                            input bit fwd);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b[9]   = (i == 0);
            b[8]   = (i == len - 1);
            b[7:0] = (i == 0) ? head : 8'($urandom_range(0, 255));
            case ({d[0], p[0]})
                2'b00:   sq0a.push_back(b);
                2'b01:   sq0b.push_back(b);
                2'b10:   sq1a.push_back(b);
                default: sq1b.push_back(b);
            endcase
            if (fwd) begin
                if (d == 0) exp_q0.push_back(b);
                else        exp_q1.push_back(b);
            end
        end
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        int rem;
        rem = sq0a.size() + sq0b.size() + sq1a.size() + sq1b.size() + exp_q0.size() + exp_q1.size();
        while (n < budget && rem != 0) begin
            @(posedge clk);
            n++;
            rem = sq0a.size() + sq0b.size() + sq1a.size() + sq1b.size() + exp_q0.size() + exp_q1.size();
        end
        check(tag, rem, 0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic clear_queues();
        sq0a.delete(); sq0b.delete(); sq1a.delete(); sq1b.delete();
        exp_q0.delete(); exp_q1.delete();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        clear_queues();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Sources and sink sampled mid-cycle; a transfer seen here happens at the next rising edge.
    always @(negedge clk) begin
        beat_t e;
        o_rdy[0] = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        o_rdy[1] = 1'b1;
        if (!rst_n) begin
            acc0a = 0; acc0b = 0; acc1a = 0; acc1b = 0;
        end
        if (acc0a && sq0a.size() > 0) void'(sq0a.pop_front());
        if (acc0b && sq0b.size() > 0) void'(sq0b.pop_front());
        if (acc1a && sq1a.size() > 0) void'(sq1a.pop_front());
        if (acc1b && sq1b.size() > 0) void'(sq1b.pop_front());
        a_valid[0] = sq0a.size() > 0;
        {a_sop[0], a_eop[0], a_data[0]} = a_valid[0] ? sq0a[0] : 10'd0;
        b_valid[0] = sq0b.size() > 0;
        {b_sop[0], b_eop[0], b_data[0]} = b_valid[0] ? sq0b[0] : 10'd0;
        a_valid[1] = sq1a.size() > 0;
        {a_sop[1], a_eop[1], a_data[1]} = a_valid[1] ? sq1a[0] : 10'd0;
        b_valid[1] = sq1b.size() > 0;
        {b_sop[1], b_eop[1], b_data[1]} = b_valid[1] ? sq1b[0] : 10'd0;
        acc0a = rst_n && a_valid[0] && a_ready[0];
        acc0b = rst_n && b_valid[0] && b_ready[0];
        acc1a = rst_n && a_valid[1] && a_ready[1];
        acc1b = rst_n && b_valid[1] && b_ready[1];

        if (rst_n && o_valid[0] && o_rdy[0]) begin
            if (exp_q0.size() == 0) begin
                check("dut0 extra beat", {22'd0, o_sop[0], o_eop[0], o_data[0]}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q0.pop_front();
                check("dut0 beat", {22'd0, o_sop[0], o_eop[0], o_data[0]}, {22'd0, e});
            end
        end
        if (rst_n && o_valid[1] && o_rdy[1]) begin
            if (exp_q1.size() == 0) begin
                check("dut1 extra beat", {22'd0, o_sop[1], o_eop[1], o_data[1]}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q1.pop_front();
                check("dut1 beat", {22'd0, o_sop[1], o_eop[1], o_data[1]}, {22'd0, e});
            end
        end
    end

    initial begin
        rst_n   = 1'b0;
        rnd_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset dout_valid", o_valid, 0);
        check("reset dout_sop", o_sop, 0);
        check("reset dout_eop", o_eop, 0);
        check("reset dout_data", o_data, 0);
        check("reset din_ready", {a_ready, b_ready}, 0);
        check("reset grant", grant, 0);
        check("reset busy", busy, 0);
        check("reset frame_count", fcnt, 0);
        check("reset drop_count", dcnt, 0);
        check("reset state", st0, ST_IDLE);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Scenario 1: input 0 alone, control then video.
        push_pkt(0, 0, 8'h0F, 10, 1);
        push_pkt(0, 0, 8'h00, 64, 1);
        wait_drain("sc1 drain", 500);
        check("sc1 frame_count", fcnt[0], 1);
        check("sc1 state", st0, ST_IDLE);
        check("sc1 busy", busy[0], 0);

        // Scenario 2: simultaneous control heads after reset; input 0 wins first.
        do_reset();
        push_pkt(0, 0, 8'h0F, 4, 1);
        push_pkt(0, 0, 8'h00, 8, 1);
        push_pkt(0, 1, 8'h0F, 5, 1);
        push_pkt(0, 1, 8'h00, 6, 1);
        wait_drain("sc2 drain", 500);
        check("sc2 frame_count", fcnt[0], 2);
        check("sc2 state", st0, ST_IDLE);

        // Scenario 3: video head dropped; control with upper nibble set, one-beat other, one-beat video.
        push_pkt(0, 1, 8'h00, 7, 0);
        push_pkt(0, 1, 8'h3F, 3, 1);
        push_pkt(0, 1, 8'h15, 1, 1);
        push_pkt(0, 1, 8'h00, 1, 1);
        wait_drain("sc3 drain", 500);
        check("sc3 drop_count", dcnt[0], 1);
        check("sc3 frame_count", fcnt[0], 3);
        check("sc3 state", st0, ST_IDLE);

        // Scenario 4: random downstream backpressure.
        rnd_rdy = 1'b1;
        push_pkt(0, 0, 8'h0F, 6, 1);
        push_pkt(0, 0, 8'h00, 200, 1);
        wait_drain("sc4 drain", 3000);
        rnd_rdy = 1'b0;
        check("sc4 frame_count", fcnt[0], 4);

        // Scenario 5: two frames per grant on dut1.
        push_pkt(1, 0, 8'h0F, 4, 1);
        push_pkt(1, 0, 8'h00, 10, 1);
        push_pkt(1, 0, 8'h00, 12, 1);
        push_pkt(1, 1, 8'h0F, 3, 1);
        push_pkt(1, 1, 8'h00, 5, 1);
        wait_drain("sc5 drain", 500);
        check("sc5 frame_count", fcnt[1], 3);
        check("sc5 drop_count", dcnt[1], 0);
        check("sc5 grant", grant[1], 1);
        check("sc5 busy", busy[1], 1);
        check("sc5 state", st1, ST_FWD);

        // Scenario 6: reset in the middle of a video packet.
        push_pkt(0, 0, 8'h0F, 10, 1);
        push_pkt(0, 0, 8'h00, 300, 1);
        repeat (60) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("sc6 dout_valid", o_valid[0], 0);
        check("sc6 dout_sop", o_sop[0], 0);
        check("sc6 dout_eop", o_eop[0], 0);
        check("sc6 dout_data", o_data[0], 0);
        check("sc6 din0_ready", a_ready[0], 0);
        check("sc6 busy", busy[0], 0);
        check("sc6 frame_count", fcnt[0], 0);
        check("sc6 drop_count", dcnt[0], 0);
        clear_queues();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        push_pkt(0, 0, 8'h0F, 5, 1);
        push_pkt(0, 0, 8'h00, 20, 1);
        wait_drain("sc6 drain", 500);
        check("sc6 post frame_count", fcnt[0], 1);
        check("sc6 post state", st0, ST_IDLE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ast_frame_arbiter.md
AST_FRAME_ARBITER -- requirements
Module: ast_frame_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8, Avalon-ST symbol width of every data port.
REQ-002 Parameter FRAMES_PER_GRANT, default 1, complete frames forwarded per grant, range 1..255.
REQ-003 clock  input  1  single clock for all logic; one clock, no other clock domain.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 din0_data/din1_data  input  DATA_WIDTH  sink data, one port per requester.
REQ-006 din0_valid, din0_startofpacket, din0_endofpacket (and din1_*)  input  1 each  sink qualifiers.
REQ-007 din0_ready/din1_ready  output  1  sink backpressure, ready latency 0.
REQ-008 dout_data  output  DATA_WIDTH  source data.
REQ-009 dout_valid, dout_startofpacket, dout_endofpacket  output  1 each  source qualifiers.
REQ-010 dout_ready  input  1  downstream backpressure, ready latency 0.
REQ-011 grant  output  1  index of the input currently owning the output; meaningful only while busy=1.
REQ-012 busy  output  1  high in FWD or DROP.
REQ-013 frame_count  output  16  completed frames forwarded, wraps 0xFFFF->0.
REQ-014 drop_count  output  16  discarded packets, wraps 0xFFFF->0.

Function
REQ-015 Transfer on any port occurs when valid and ready are both high on a rising clock edge.
REQ-016 Packet type is data[3:0] of the SOP beat: 0xF control, 0x0 video, any other value "other".
REQ-017 FSM states: IDLE, FWD, DROP.
REQ-018 IDLE: both din*_ready low; candidates are inputs with valid=1 and startofpacket=1.
REQ-019 IDLE arbitration: single candidate wins; with two candidates, the input not granted last wins (round-robin); after reset, last_grant=1, so input 0 wins first.
REQ-020 IDLE, winner head type 0xF: grant<=winner, frames_in_grant<=0, next state FWD; the SOP beat is not consumed in IDLE.
REQ-021 IDLE, winner head type not 0xF: grant<=winner, next state DROP.
REQ-022 FWD: din[grant]_ready = skid-buffer ready; the other din*_ready is low; accepted beats pass unchanged into the output skid buffer.
REQ-023 FWD: type is latched at each accepted SOP; on an accepted EOP of a type-0x0 packet, frame_count and frames_in_grant increment.
REQ-024 FWD: when frames_in_grant reaches FRAMES_PER_GRANT on that EOP, last_grant<=grant and next state is IDLE; otherwise stay in FWD.
REQ-025 FWD: an accepted EOP of a control or other packet keeps FWD.
REQ-026 DROP: din[grant]_ready=1 regardless of dout_ready; beats are discarded; on an accepted EOP, drop_count increments, last_grant<=grant, next state IDLE.
REQ-027 SOP and EOP on the same beat form a one-beat packet; in FWD it counts as a frame only if its type is 0x0.
REQ-028 Latency: a beat accepted at edge N appears on dout at edge N+1 when the buffer was empty; no bubbles under continuous valid/ready.
REQ-029 The output never interleaves beats of two inputs; grant changes only in IDLE.
REQ-030 A beat accepted by the skid buffer is never lost or duplicated under any dout_ready pattern.

Reset
REQ-031 Reset asserted: FSM<=IDLE, grant<=0, last_grant<=1, frames_in_grant<=0, frame_count<=0, drop_count<=0, skid buffer emptied.
REQ-032 Reset asserted: all outputs 0.
REQ-033 Reset asserted mid-packet: the partial packet is abandoned; no EOP is emitted; after release, arbitration restarts in IDLE.

Structure
REQ-034 A shared package holds the packet-type constants (PKT_CTRL=4'hF, PKT_VIDEO=4'h0) and the FSM state enum, for reuse by bt656 video blocks.
REQ-035 Output buffering is one sub-module, ast_skid_buffer: 2-entry, registered outputs, ready = not-full, parameterised by DATA_WIDTH+2.

Verification
REQ-036 Scenario 1: input 0 only; control packet (0x0F + 9 beats, EOP) then video packet (0x00 + 1440*288 beats), dout_ready=1 -> identical stream on dout; frame_count=1; back in IDLE.
REQ-037 Scenario 2: both inputs offer control SOP in the same cycle after reset -> input 0 served first, then input 1; output has no interleaving; frame_count=2.
REQ-038 Scenario 3: input 1 head SOP data 0x00 in IDLE -> packet fully consumed, nothing on dout, drop_count=1; the following 0x0F packet is forwarded.
REQ-039 Scenario 4: dout_ready random 50% during a video packet -> dout beat sequence equals the input sequence exactly, with no loss or duplication.
REQ-040 Scenario 5: FRAMES_PER_GRANT=2, both inputs streaming -> two full frames from input 0 before any beat from input 1.
REQ-041 Scenario 6: reset asserted mid-video packet -> all outputs 0 immediately; after release, the next control SOP is forwarded normally.
